hybrid_angle_sequencer: RTL and testbench



---
 rtl/hybrid_seq_pkg.sv | 28 ++
 rtl/hybrid_angle_sequencer_if.sv | 27 ++
 rtl/angle_slew.sv | 57 +++++
 rtl/hybrid_angle_sequencer.sv | 156 +++++++++++++++
 tb/tb_hybrid_angle_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/hybrid_seq_pkg.sv
// Shared types and constants for the hybrid converter angle sequencer.
// State encoding, angle width, sigma codes and the signed clamp helper.
package hybrid_seq_pkg;

  localparam int unsigned ANGLE_W = 32;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StRun   = 3'd2,
    StFault = 3'd3
  } seq_state_e;

  localparam logic [1:0] SIG_POS  = 2'b01;
  localparam logic [1:0] SIG_ZERO = 2'b00;
  localparam logic [1:0] SIG_NEG  = 2'b11;

  function automatic logic signed [ANGLE_W-1:0] clamp_angle(
    input logic signed [ANGLE_W-1:0] v,
    input logic signed [ANGLE_W-1:0] lo,
    input logic signed [ANGLE_W-1:0] hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/hybrid_angle_sequencer_if.sv
// Control/angle bundle between the parameter registers and the sequencer.
// The sequencer takes the slave modport; the register side / bench takes master.
interface hybrid_angle_sequencer_if;

  logic                                        i_enable;
  logic                                        i_fault;
  logic [1:0]                                  i_sigma;
  logic signed [hybrid_seq_pkg::ANGLE_W-1:0]   i_ZVS_target;
  logic signed [hybrid_seq_pkg::ANGLE_W-1:0]   i_phi_target;
  logic signed [hybrid_seq_pkg::ANGLE_W-1:0]   o_ZVS;
  logic signed [hybrid_seq_pkg::ANGLE_W-1:0]   o_phi;
  logic                                        o_ctrl_RESET;
  logic                                        o_ready;
  logic                                        o_fault;
  logic [2:0]                                  o_state;

  modport slave (
    input  i_enable, i_fault, i_sigma, i_ZVS_target, i_phi_target,
    output o_ZVS, o_phi, o_ctrl_RESET, o_ready, o_fault, o_state
  );

  modport master (
    output i_enable, i_fault, i_sigma, i_ZVS_target, i_phi_target,
    input  o_ZVS, o_phi, o_ctrl_RESET, o_ready, o_fault, o_state
  );

endinterface

// File: rtl/angle_slew.sv
// One slew-limited angle: clamps its target and steps the registered angle toward it
// by at most STEP per enabled cycle; load_init snaps it back to the init value.
module angle_slew
  import hybrid_seq_pkg::*;
#(
  parameter int signed MIN     = 32'sd0,
  parameter int signed MAX     = 32'sd80,
  parameter int signed STEP    = 32'sd1,
  parameter int signed RST_VAL = 32'sd0
) (
  input  logic                      i_clock,
  input  logic                      i_RESET,
  input  logic signed [ANGLE_W-1:0] target,
  input  logic                      step_en,
  input  logic                      load_init,
  input  logic signed [ANGLE_W-1:0] init_val,
  output logic signed [ANGLE_W-1:0] angle,
  output logic                      at_target
);

  localparam logic signed [ANGLE_W:0] StepW = (ANGLE_W+1)'(STEP);

  logic signed [ANGLE_W-1:0] tgt;
  logic signed [ANGLE_W-1:0] angle_q, angle_d;
  logic signed [ANGLE_W:0]   diff;

  assign tgt  = clamp_angle(target, MIN, MAX);
  // 33-bit difference so extreme targets cannot wrap the sign
  assign diff = {tgt[ANGLE_W-1], tgt} - {angle_q[ANGLE_W-1], angle_q};

  always_comb begin
    angle_d = angle_q;
    if (load_init) begin
      angle_d = init_val;
    end else if (step_en) begin
      if (diff <= StepW && diff >= -StepW) begin
        angle_d = tgt;
      end else if (!diff[ANGLE_W]) begin
        angle_d = angle_q + ANGLE_W'(STEP);
      end else begin
        angle_d = angle_q - ANGLE_W'(STEP);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      angle_q <= ANGLE_W'(RST_VAL);
    end else begin
      angle_q <= angle_d;
    end
  end

  assign angle     = angle_q;
  assign at_target = (angle_d == tgt);

endmodule

// File: rtl/hybrid_angle_sequencer.sv
// Start-up / run / fault sequencer owning the hybrid controller reset and angle inputs.
// Optional sigma-activity watchdog enabled by defining HYBRID_SEQ_WATCHDOG_EN.
module hybrid_angle_sequencer
  import hybrid_seq_pkg::*;
#(
  parameter int signed   ZVS_INIT        = 32'sd10,
  parameter int signed   ZVS_MIN         = 32'sd0,
  parameter int signed   ZVS_MAX         = 32'sd80,
  parameter int signed   PHI_MAX         = 32'sd90,
  parameter int signed   STEP_ZVS        = 32'sd1,
  parameter int signed   STEP_PHI        = 32'sd1,
  parameter int unsigned STARTUP_CYCLES  = 1000,
  parameter int unsigned WATCHDOG_CYCLES = 50000
) (
  input logic                     i_clock,
  input logic                     i_RESET,
  hybrid_angle_sequencer_if.slave bus
);

  seq_state_e  state_q, state_d;
  logic [1:0]  s1_q, s2_q, s3_q;
  logic        evt, evt_q;
  logic [31:0] start_cnt_q, start_cnt_d;
  logic        ctrl_rst_q, fault_q, ready_q;
  logic        zvs_at, phi_at;
  logic        step_en, load_init;

  // Sigma synchronizer plus history; an event is any code change after sync.
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      s1_q  <= SIG_ZERO;
      s2_q  <= SIG_ZERO;
      s3_q  <= SIG_ZERO;
      evt_q <= 1'b0;
    end else begin
      s1_q  <= bus.i_sigma;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      evt_q <= evt;
    end
  end

  assign evt = (s2_q != s3_q);

`ifdef HYBRID_SEQ_WATCHDOG_EN
  logic [31:0] wd_q, wd_d;

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    start_cnt_d = '0;
`ifdef HYBRID_SEQ_WATCHDOG_EN
    wd_d        = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.i_enable && !bus.i_fault) state_d = StStart;
      end
      StStart: begin
        if (bus.i_fault) begin
          state_d = StFault;
        end else if (!bus.i_enable) begin
          state_d = StIdle;
        end else if (start_cnt_q == STARTUP_CYCLES - 1) begin
          state_d = StRun;
        end else begin
          start_cnt_d = start_cnt_q + 32'd1;
        end
      end
      StRun: begin
        if (bus.i_fault) begin
          state_d = StFault;
        end else if (!bus.i_enable) begin
          state_d = StIdle;
        end
`ifdef HYBRID_SEQ_WATCHDOG_EN
        else if (wd_q >= WATCHDOG_CYCLES) begin
          state_d = StFault;
        end else begin
          wd_d = evt ? '0 : wd_q + 32'd1;
        end
`endif
      end
      StFault: begin
        if (!bus.i_enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Angles follow the next state so they snap to init on the same edge that leaves RUN.
  assign load_init = (state_d != StRun);
  assign step_en   = evt_q && (state_q == StRun) && (state_d == StRun);

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      state_q     <= StIdle;
      start_cnt_q <= '0;
      ctrl_rst_q  <= 1'b0;
      fault_q     <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      ctrl_rst_q  <= (state_d == StStart) || (state_d == StRun);
      fault_q     <= (state_d == StFault);
      ready_q     <= (state_d == StRun) && zvs_at && phi_at;
    end
  end

  angle_slew #(
    .MIN     (ZVS_MIN),
    .MAX     (ZVS_MAX),
    .STEP    (STEP_ZVS),
    .RST_VAL (ZVS_INIT)
  ) u_zvs (
    .i_clock   (i_clock),
    .i_RESET   (i_RESET),
    .target    (bus.i_ZVS_target),
    .step_en   (step_en),
    .load_init (load_init),
    .init_val  (ANGLE_W'(ZVS_INIT)),
    .angle     (bus.o_ZVS),
    .at_target (zvs_at)
  );

  angle_slew #(
    .MIN     (32'sd0),
    .MAX     (PHI_MAX),
    .STEP    (STEP_PHI),
    .RST_VAL (32'sd0)
  ) u_phi (
    .i_clock   (i_clock),
    .i_RESET   (i_RESET),
    .target    (bus.i_phi_target),
    .step_en   (step_en),
    .load_init (load_init),
    .init_val  ('0),
    .angle     (bus.o_phi),
    .at_target (phi_at)
  );

  assign bus.o_ctrl_RESET = ctrl_rst_q;
  assign bus.o_fault      = fault_q;
  assign bus.o_ready      = ready_q;
  assign bus.o_state      = state_q;

endmodule

// File: tb/tb_hybrid_angle_sequencer.sv
// Self-checking bench for hybrid_angle_sequencer: directed sequence with randomized
// targets and sigma codes, checked against a per-event slew model.
module tb_hybrid_angle_sequencer;
  import hybrid_seq_pkg::*;

  localparam int ZvsInit = 10;
  localparam int ZvsMax  = 80;
  localparam int PhiMax  = 90;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   mz, mp;
  logic [1:0] codes [3];

  hybrid_angle_sequencer_if bus ();

  hybrid_angle_sequencer #(
    .WATCHDOG_CYCLES (100)
  ) dut (
    .i_clock (clk),
    .i_RESET (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int slew(input int cur, input int tgt);
    int d;
    d = tgt - cur;
    if (d >= -1 && d <= 1) return tgt;
    return (d > 0) ? cur + 1 : cur - 1;
  endfunction

  task automatic new_sigma();
    logic [1:0] v;
    v = bus.i_sigma;
    while (v == bus.i_sigma) v = codes[$urandom_range(0, 2)];
    bus.i_sigma = v;
  endtask

  // One sigma change with given targets; the step must land exactly 3 edges after capture.
  task automatic do_event(input int tz, input int tp, input int gap);
    int cz, cp, oz, op;
    bus.i_ZVS_target = tz;
    bus.i_phi_target = tp;
    new_sigma();
    oz = mz;
    op = mp;
    cz = clampi(tz, 0, ZvsMax);
    cp = clampi(tp, 0, PhiMax);
    mz = slew(mz, cz);
    mp = slew(mp, cp);
    repeat (3) tick();
    chk("zvs_before_step", bus.o_ZVS, oz);
    chk("phi_before_step", bus.o_phi, op);
    tick();
    chk("zvs_step", bus.o_ZVS, mz);
    chk("phi_step", bus.o_phi, mp);
    chk("ready", 32'(bus.o_ready), 32'((mz == cz) && (mp == cp)));
    repeat (gap) tick();
  endtask

  task automatic start_run();
    bus.i_enable = 1'b1;
    tick();
    chk("start_state", 32'(bus.o_state), 1);
    chk("start_ctrl_rst", 32'(bus.o_ctrl_RESET), 1);
    repeat (999) tick();
    chk("start_state_last", 32'(bus.o_state), 1);
    chk("start_zvs", bus.o_ZVS, ZvsInit);
    chk("start_phi", bus.o_phi, 0);
    tick();
    chk("run_state", 32'(bus.o_state), 2);
    mz = ZvsInit;
    mp = 0;
  endtask

  initial begin
    int zv[5];
    int guard;
    n_vec = 0;
    n_err = 0;
    codes[0] = SIG_POS;
    codes[1] = SIG_ZERO;
    codes[2] = SIG_NEG;
    bus.i_enable     = 1'b0;
    bus.i_fault      = 1'b0;
    bus.i_sigma      = SIG_ZERO;
    bus.i_ZVS_target = 15;
    bus.i_phi_target = 3;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) tick();
    chk("rst_state", 32'(bus.o_state), 0);
    chk("rst_zvs", bus.o_ZVS, ZvsInit);
    chk("rst_phi", bus.o_phi, 0);
    chk("rst_ctrl", 32'(bus.o_ctrl_RESET), 0);
    chk("rst_ready", 32'(bus.o_ready), 0);
    chk("rst_fault", 32'(bus.o_fault), 0);
    rst = 1'b1;
    tick();

    // Start-up then ramp to 15/3: ZVS 11..15, phi 1..3
    start_run();
    chk("run_ready_low", 32'(bus.o_ready), 0);
    zv = '{11, 12, 13, 14, 15};
    for (int i = 0; i < 5; i++) begin
      do_event(15, 3, 20);
      chk("ramp_zvs_abs", bus.o_ZVS, zv[i]);
    end
    chk("ramp_ready_final", 32'(bus.o_ready), 1);

    // Randomized targets, including out-of-range ones
    for (int i = 0; i < 12; i++) begin
      do_event(int'($urandom_range(0, 140)) - 20, int'($urandom_range(0, 110)) - 10,
               int'($urandom_range(0, 20)));
    end

    // Saturation at ZVS_MAX and phi floor
    guard = 0;
    while ((mz != ZvsMax || mp != 0) && guard < 120) begin
      do_event(120, -5, 1);
      guard++;
    end
    chk("sat_zvs", bus.o_ZVS, ZvsMax);
    chk("sat_phi", bus.o_phi, 0);
    chk("sat_ready", 32'(bus.o_ready), 1);

    // Fault coincident with sigma change
    new_sigma();
    bus.i_fault = 1'b1;
    tick();
    chk("flt_state", 32'(bus.o_state), 3);
    chk("flt_ctrl", 32'(bus.o_ctrl_RESET), 0);
    chk("flt_flag", 32'(bus.o_fault), 1);
    chk("flt_zvs", bus.o_ZVS, ZvsInit);
    chk("flt_phi", bus.o_phi, 0);
    repeat (4) tick();
    chk("flt_zvs_hold", bus.o_ZVS, ZvsInit);
    bus.i_fault = 1'b0;
    tick();
    chk("flt_sticky_en", 32'(bus.o_state), 3);
    chk("flt_flag_sticky", 32'(bus.o_fault), 1);
    bus.i_enable = 1'b0;
    tick();
    chk("flt_exit_state", 32'(bus.o_state), 0);
    chk("flt_exit_flag", 32'(bus.o_fault), 0);

    // Async reset mid-ramp
    start_run();
    do_event(60, 50, 2);
    do_event(60, 50, 2);
    new_sigma();
    tick();
    #3 rst = 1'b0;
    #1;
    chk("arst_state", 32'(bus.o_state), 0);
    chk("arst_zvs", bus.o_ZVS, ZvsInit);
    chk("arst_phi", bus.o_phi, 0);
    chk("arst_ctrl", 32'(bus.o_ctrl_RESET), 0);
    chk("arst_ready", 32'(bus.o_ready), 0);
    chk("arst_fault", 32'(bus.o_fault), 0);
    bus.i_enable = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("arst_idle", 32'(bus.o_state), 0);

    // Frozen sigma in RUN
    start_run();
`ifdef HYBRID_SEQ_WATCHDOG_EN
    repeat (99) tick();
    chk("wd_not_yet", 32'(bus.o_state), 2);
    guard = 0;
    while (bus.o_state != 3'd3 && guard < 5) begin
      tick();
      guard++;
    end
    chk("wd_fault", 32'(bus.o_state), 3);
    chk("wd_fault_flag", 32'(bus.o_fault), 1);
`else
    repeat (150) tick();
    chk("no_wd_run", 32'(bus.o_state), 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
